// File: rtl/harness_run_sequencer.sv
// ---------------------------------------------------------------------------
// harness_run_sequencer: staged reset release, run-cycle counting and sticky
// pass/fail/timeout verdict. Optional heartbeat: HARNESS_RUN_HEARTBEAT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module harness_run_sequencer #(
  parameter int ADC_RESET_CYCLES  = 37,
  parameter int CORE_RESET_CYCLES = 77,
  parameter int SUCCESS_HOLD      = 2,
  parameter int CNT_W             = 64
`ifdef HARNESS_RUN_HEARTBEAT_EN
  ,
  parameter int HB_LOG2           = 10
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic             success_in,
  input  logic             failure_in,
  output logic             adc_reset,
  output logic             core_reset,
  output logic             dsp_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
`ifdef HARNESS_RUN_HEARTBEAT_EN
  output logic             heartbeat,
`endif
  output logic [CNT_W-1:0] cycle_count
);

  localparam int SEQ_W = $clog2(CORE_RESET_CYCLES + 1);
  localparam int SUC_W = $clog2(SUCCESS_HOLD + 1);
  localparam logic [SEQ_W-1:0] C_ADC_LAST  = SEQ_W'(ADC_RESET_CYCLES - 1);
  localparam logic [SEQ_W-1:0] C_CORE_LAST = SEQ_W'(CORE_RESET_CYCLES - 1);
  localparam logic [SUC_W-1:0] C_SUC_MAX   = SUC_W'(SUCCESS_HOLD);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_PASS = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SUC_W-1:0] succ_q, succ_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adc_q, adc_d;
  logic             core_q, core_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             to_q, to_d;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [SUC_W-1:0] w_succ_inc;
  logic             w_pass_hit;
  logic             w_timeout_hit;

  assign w_cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign w_succ_inc    = (succ_q >= C_SUC_MAX) ? C_SUC_MAX : succ_q + 1'b1;
  assign w_pass_hit    = success_in && (w_succ_inc == C_SUC_MAX);
  assign w_timeout_hit = (max_q != '0) && (cnt_q == max_q);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    succ_d  = succ_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    adc_d   = adc_q;
    core_d  = core_q;
    run_d   = run_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HOLD;
          seq_d   = '0;
          max_d   = max_cycles;
        end
      end
      S_HOLD: begin
        seq_d = seq_q + 1'b1;
        if (seq_q == C_ADC_LAST) adc_d = 1'b0;
        if (seq_q == C_CORE_LAST) begin
          core_d  = 1'b0;
          run_d   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d  = w_cnt_inc;
        succ_d = success_in ? w_succ_inc : '0;
        // Failure outranks timeout, which outranks success.
        if (failure_in) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else if (w_timeout_hit) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          to_d    = 1'b1;
        end else if (w_pass_hit) begin
          state_d = S_PASS;
          pass_d  = 1'b1;
        end
        if (failure_in || w_timeout_hit || w_pass_hit) begin
          done_d = 1'b1;
          run_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      succ_q  <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      adc_q   <= 1'b1;
      core_q  <= 1'b1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      succ_q  <= succ_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      adc_q   <= adc_d;
      core_q  <= core_d;
      run_q   <= run_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

`ifdef HARNESS_RUN_HEARTBEAT_EN
  logic hb_q, hb_d;

  always_comb begin
    hb_d = 1'b0;
    if (state_q == S_RUN) hb_d = (w_cnt_inc[HB_LOG2-1:0] == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) hb_q <= 1'b0;
    else          hb_q <= hb_d;
  end

  assign heartbeat = hb_q;
`endif

  assign adc_reset   = adc_q;
  assign core_reset  = core_q;
  assign dsp_reset   = core_q;
  assign running     = run_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = to_q;
  assign cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_harness_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_harness_run_sequencer: directed scoreboard bench for harness_run_sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_harness_run_sequencer;

  localparam int ADC  = 4;
  localparam int CORE = 8;
  localparam int SH   = 2;
  localparam int W    = 8;
  localparam int HB   = 2;

  logic         clock = 1'b0;
  logic         reset_n, start, success_in, failure_in;
  logic [W-1:0] max_cycles;
  logic         adc_reset, core_reset, dsp_reset, running, done, pass, fail, timeout;
  logic [W-1:0] cycle_count;
`ifdef HARNESS_RUN_HEARTBEAT_EN
  logic         heartbeat;
`endif

  always #5 clock = ~clock;

  harness_run_sequencer #(
    .ADC_RESET_CYCLES (ADC),
    .CORE_RESET_CYCLES(CORE),
    .SUCCESS_HOLD     (SH),
    .CNT_W            (W)
`ifdef HARNESS_RUN_HEARTBEAT_EN
    ,
    .HB_LOG2          (HB)
`endif
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .max_cycles (max_cycles),
    .success_in (success_in),
    .failure_in (failure_in),
    .adc_reset  (adc_reset),
    .core_reset (core_reset),
    .dsp_reset  (dsp_reset),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
`ifdef HARNESS_RUN_HEARTBEAT_EN
    .heartbeat  (heartbeat),
`endif
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic         adc, core, run, done, ps, fl, to, hb;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic exp_t mk(logic adc, logic core, logic run, logic dn, logic ps,
                              logic fl, logic to, int cnt, logic hb);
    exp_t e;
    e.adc = adc; e.core = core; e.run = run; e.done = dn; e.ps = ps;
    e.fl = fl; e.to = to; e.cnt = W'(cnt); e.hb = hb;
    return e;
  endfunction

  // Expected heartbeat for a RUN edge whose incremented count is nxt.
  function automatic logic hbx(int nxt);
    return (nxt % (1 << HB)) == 0;
  endfunction

  function automatic int sat(int n);
    return (n > (1 << W) - 1) ? (1 << W) - 1 : n;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] ex);
    n_total++;
    assert (obs === ex) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".adc"},  W'(adc_reset),  W'(e.adc));
      chk({tag, ".core"}, W'(core_reset), W'(e.core));
      chk({tag, ".dsp"},  W'(dsp_reset),  W'(e.core));
      chk({tag, ".run"},  W'(running),    W'(e.run));
      chk({tag, ".done"}, W'(done),       W'(e.done));
      chk({tag, ".pass"}, W'(pass),       W'(e.ps));
      chk({tag, ".fail"}, W'(fail),       W'(e.fl));
      chk({tag, ".to"},   W'(timeout),    W'(e.to));
      chk({tag, ".cnt"},  cycle_count,    e.cnt);
`ifdef HARNESS_RUN_HEARTBEAT_EN
      chk({tag, ".hb"},   W'(heartbeat),  W'(e.hb));
`endif
    end
  endtask

  task automatic cyc(input logic s, input logic suc, input logic fl,
                     input exp_t e, input string tag);
    start = s; success_in = suc; failure_in = fl;
    sb.push_back(e);
    @(posedge clock);
    #1;
    pop_check(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "rst");
    reset_n = 1'b1;
  endtask

  // Hold edges 1..upto after the accepted start; start is pulsed to prove it is ignored.
  task automatic hold_edges(input int upto);
    for (int k = 1; k <= upto; k++)
      cyc(k == 3, 1'b0, 1'b0,
          mk(k < ADC, k < CORE, k == CORE, 0, 0, 0, 0, 0, 0), "hold");
  endtask

  task automatic do_start(input int m);
    max_cycles = W'(m);
    cyc(1'b1, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "E0");
    max_cycles = 8'hAA;
    hold_edges(CORE);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; success_in = 1'b0; failure_in = 1'b0;
    max_cycles = '0;
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "idle");

    // Single success pulse must not pass; two consecutive highs from count 10 do.
    do_start(0);
    for (int c = 0; c <= 11; c++) begin
      logic last;
      last = (c == 11);
      cyc(1'b0, (c == 5) || (c == 10) || (c == 11), 1'b0,
          mk(0, 0, !last, last, last, 0, 0, c + 1, hbx(c + 1)), "A_run");
    end
    for (int k = 0; k < 5; k++)
      cyc(k[0], 1'b1, k == 2, mk(0, 0, 0, 1, 1, 0, 0, 12, 0), "A_term");

    // Timeout at max=5, then sticky through 20 cycles and a new start.
    do_reset();
    do_start(5);
    for (int c = 0; c <= 5; c++) begin
      logic last;
      last = (c == 5);
      cyc(1'b0, 1'b0, 1'b0,
          mk(0, 0, !last, last, 0, last, last, c + 1, hbx(c + 1)), "B_run");
    end
    for (int k = 0; k < 20; k++)
      cyc(k == 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          mk(0, 0, 0, 1, 0, 1, 1, 6, 0), "B_term");

    // Failure coincident with the second success sample.
    do_reset();
    do_start(0);
    for (int c = 0; c <= 3; c++) begin
      logic last;
      last = (c == 3);
      cyc(1'b0, c >= 2, last,
          mk(0, 0, !last, last, 0, last, 0, c + 1, hbx(c + 1)), "C_run");
    end

    // Timeout coincident with the second success sample.
    do_reset();
    do_start(3);
    for (int c = 0; c <= 3; c++) begin
      logic last;
      last = (c == 3);
      cyc(1'b0, c >= 2, 1'b0,
          mk(0, 0, !last, last, 0, last, last, c + 1, hbx(c + 1)), "D_run");
    end

    // Failure coincident with timeout: plain failure, no timeout flag.
    do_reset();
    do_start(2);
    for (int c = 0; c <= 2; c++) begin
      logic last;
      last = (c == 2);
      cyc(1'b0, 1'b0, last,
          mk(0, 0, !last, last, 0, last, 0, c + 1, hbx(c + 1)), "E_run");
    end

    // Reset during HOLD at seq=5, then a clean restart repeats the timing.
    do_reset();
    max_cycles = '0;
    cyc(1'b1, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "F_E0");
    hold_edges(5);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "F_idle");
    do_start(0);

    // Saturating count with no timeout, then a pass at the ceiling.
    for (int c = 0; c < 300; c++)
      cyc(1'b0, 1'b0, 1'b0,
          mk(0, 0, 1, 0, 0, 0, 0, sat(c + 1), (c + 1 < 256) && hbx(c + 1)), "G_sat");
    cyc(1'b0, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 255, 0), "G_s1");
    cyc(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 255, 0), "G_s2");
    cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 255, 0), "G_term");

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
